// File: rtl/blackjack_turn_ctrl.sv
// Blackjack round sequencer: deal, player turn, dealer draw, outcome.
// Optional idle-player timeout enabled by BLACKJACK_TURN_TIMEOUT_EN.
module blackjack_turn_ctrl #(
  parameter int MAX_CARDS      = 9,
  parameter int DEALER_STAND   = 17,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   hit,
  input  logic                   stand,
  output logic                   card_req,
  input  logic                   card_valid,
  input  logic [3:0]             card_value,
  output logic [4*MAX_CARDS-1:0] player_cards,
  output logic [4*MAX_CARDS-1:0] dealer_cards,
  input  logic [5:0]             player_total,
  input  logic [5:0]             dealer_total,
  output logic                   player_turn,
  output logic                   busy,
  output logic [1:0]             result,
  output logic                   result_valid
);

  localparam int CW = $clog2(MAX_CARDS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DEAL, S_P_WAIT, S_P_DRAW, S_P_SETTLE,
    S_D_CHECK, S_D_DRAW, S_D_SETTLE, S_RESULT
  } state_t;

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_pcnt, r_dcnt, w_nd;
  logic [3:0]             r_settle;
  logic                   r_req, r_rv;
  logic [1:0]             r_result, w_res;
  logic [4*MAX_CARDS-1:0] r_pc, r_dc;
  logic                   w_acc, w_need, w_to_p;
  logic                   w_pfull, w_dfull, w_clr;
  logic                   w_in_settle, w_set_done, w_tmo;

  assign w_nd        = r_pcnt + r_dcnt;
  assign w_pfull     = r_pcnt == CW'(MAX_CARDS);
  assign w_dfull     = r_dcnt == CW'(MAX_CARDS);
  assign w_acc       = r_req & card_valid &
                       (card_value != 4'd0) & (card_value <= 4'd13);
  assign w_need      = (r_state == S_DEAL && w_nd < CW'(4)) ||
                       r_state == S_P_DRAW || r_state == S_D_DRAW;
  // Deal alternates player/dealer, so the running total's parity picks the side.
  assign w_to_p      = (r_state == S_DEAL && !w_nd[0]) ||
                       r_state == S_P_DRAW;
  assign w_clr       = start &&
                       (r_state == S_IDLE || r_state == S_RESULT);
  assign w_in_settle = r_state == S_P_SETTLE || r_state == S_D_SETTLE;
  assign w_set_done  = r_settle == 4'(SETTLE_CYCLES - 1);

`ifdef BLACKJACK_TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  assign w_tmo = r_state == S_P_WAIT &&
                 r_tmo == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_tmo <= '0;
    else if (r_state == S_P_WAIT && !hit && !stand && !w_tmo)
      r_tmo <= r_tmo + TW'(1);
    else
      r_tmo <= '0;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_res = 2'b11;
    if (player_total > 6'd21)
      w_res = 2'b10;
    else if (dealer_total > 6'd21)
      w_res = 2'b01;
    else if (player_total > dealer_total)
      w_res = 2'b01;
    else if (player_total < dealer_total)
      w_res = 2'b10;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start) w_next = S_DEAL;
      S_DEAL:     if (w_acc && w_nd == CW'(3)) w_next = S_P_SETTLE;
      S_P_WAIT: begin
        if (player_total > 6'd21)
          w_next = S_RESULT;
        else if (w_pfull || stand || w_tmo)
          w_next = S_D_CHECK;
        else if (hit)
          w_next = S_P_DRAW;
      end
      S_P_DRAW:   if (w_acc) w_next = S_P_SETTLE;
      S_P_SETTLE: if (w_set_done) w_next = S_P_WAIT;
      S_D_CHECK: begin
        if (dealer_total >= 6'(DEALER_STAND) || w_dfull)
          w_next = S_RESULT;
        else
          w_next = S_D_DRAW;
      end
      S_D_DRAW:   if (w_acc) w_next = S_D_SETTLE;
      S_D_SETTLE: if (w_set_done) w_next = S_D_CHECK;
      S_RESULT:   if (start) w_next = S_DEAL;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pcnt   <= '0;
      r_dcnt   <= '0;
      r_pc     <= '0;
      r_dc     <= '0;
      r_settle <= '0;
      r_req    <= 1'b0;
      r_result <= 2'b00;
      r_rv     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_req    <= w_need & ~w_acc;
      r_settle <= (w_in_settle && !w_set_done) ?
                  r_settle + 4'd1 : 4'd0;
      if (w_clr) begin
        r_pcnt <= '0;
        r_dcnt <= '0;
        r_pc   <= '0;
        r_dc   <= '0;
      end else if (w_acc) begin
        if (w_to_p) begin
          if (!w_pfull) begin
            r_pc[{r_pcnt, 2'b00} +: 4] <= card_value;
            r_pcnt <= r_pcnt + CW'(1);
          end
        end else if (!w_dfull) begin
          r_dc[{r_dcnt, 2'b00} +: 4] <= card_value;
          r_dcnt <= r_dcnt + CW'(1);
        end
      end
      r_rv <= w_next == S_RESULT;
      if (w_next != S_RESULT)
        r_result <= 2'b00;
      else if (r_state != S_RESULT)
        r_result <= w_res;
    end
  end

  assign card_req     = r_req;
  assign player_cards = r_pc;
  assign dealer_cards = r_dc;
  assign player_turn  = r_state == S_P_WAIT;
  assign busy         = r_state != S_IDLE && r_state != S_RESULT;
  assign result       = r_result;
  assign result_valid = r_rv;

endmodule

// File: tb/tb_blackjack_turn_ctrl.sv
// Directed bench for blackjack_turn_ctrl with a registered hand-value model.
// Timeout checks run when BLACKJACK_TURN_TIMEOUT_EN is defined.
module tb_blackjack_turn_ctrl;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        hit = 1'b0;
  logic        stand = 1'b0;
  logic        card_valid = 1'b0;
  logic [3:0]  card_value = 4'd0;
  logic        card_req;
  logic [35:0] player_cards, dealer_cards;
  logic [5:0]  pt = 6'd0;
  logic [5:0]  dt = 6'd0;
  logic        player_turn, busy, result_valid;
  logic [1:0]  result;

  int errs = 0;
  int checks = 0;

  blackjack_turn_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit),
    .stand(stand), .card_req(card_req),
    .card_valid(card_valid), .card_value(card_value),
    .player_cards(player_cards), .dealer_cards(dealer_cards),
    .player_total(pt), .dealer_total(dt),
    .player_turn(player_turn), .busy(busy),
    .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] calc(input logic [35:0] c);
    int s = 0;
    bit ace = 0;
    for (int i = 0; i < 9; i++) begin
      int v = int'(c[4*i +: 4]);
      if (v == 1) ace = 1;
      s += (v > 10) ? 10 : v;
    end
    if (ace && s + 10 <= 21) s += 10;
    if (s > 63) s = 63;
    return 6'(s);
  endfunction

  always @(posedge clk) begin
    pt <= calc(player_cards);
    dt <= calc(dealer_cards);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!card_req && n < 60) begin
      tick();
      n++;
    end
    chk("req_seen", 64'(card_req), 64'd1);
  endtask

  task automatic feed(input logic [3:0] v);
    wait_req();
    if (card_req) begin
      card_valid = 1'b1;
      card_value = v;
      tick();
      card_valid = 1'b0;
      card_value = 4'd0;
      chk("req_drop", 64'(card_req), 64'd0);
    end
  endtask

  task automatic wait_turn();
    int n = 0;
    while (!player_turn && !result_valid && n < 60) begin
      tick();
      n++;
    end
    chk("turn_seen", 64'(player_turn | result_valid), 64'd1);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!result_valid && n < 100) begin
      tick();
      n++;
    end
    chk("res_seen", 64'(result_valid), 64'd1);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: start = 1'b1;
      1: hit = 1'b1;
      default: stand = 1'b1;
    endcase
    tick();
    start = 1'b0;
    hit = 1'b0;
    stand = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0] deal;
    logic [31:0] ph;
    logic [3:0]  nh;
    logic        st;
    logic [15:0] dd;
    logic [3:0]  nd;
    logic [1:0]  res;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [35:0] pe, de;
    logic [3:0]  v;
    int          pc, dc;

    vt[0] = '{16'hA795, 32'h0, 4'd0, 1'b1, 16'h6000, 4'd1, 2'b01};
    vt[1] = '{16'hA968, 32'hD000_0000, 4'd1, 1'b0, 16'h0, 4'd0, 2'b10};
    vt[2] = '{16'hAA88, 32'h0, 4'd0, 1'b1, 16'h0, 4'd0, 2'b11};
    vt[3] = '{16'h1A56, 32'h5000_0000, 4'd1, 1'b1, 16'hA000, 4'd1, 2'b01};
    vt[4] = '{16'hAA72, 32'h0, 4'd0, 1'b1, 16'h3200, 4'd2, 2'b11};
    vt[5] = '{16'h9A9A, 32'h0, 4'd0, 1'b1, 16'h0, 4'd0, 2'b10};
    vt[6] = '{16'h1A17, 32'h1111_1110, 4'd7, 1'b0, 16'h0, 4'd0, 2'b01};

    repeat (2) tick();
    chk("rst_req", 64'(card_req), 64'd0);
    chk("rst_pc", 64'(player_cards), 64'd0);
    chk("rst_dc", 64'(dealer_cards), 64'd0);
    chk("rst_res", 64'(result), 64'd0);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_turn", 64'(player_turn), 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      pe = '0;
      de = '0;
      pc = 0;
      dc = 0;
      pulse(0);
      chk("clr_pc", 64'(player_cards), 64'd0);
      chk("clr_dc", 64'(dealer_cards), 64'd0);
      chk("deal_busy", 64'(busy), 64'd1);
      chk("deal_rv", 64'(result_valid), 64'd0);
      for (int k = 0; k < 4; k++) begin
        v = vt[i].deal[15-4*k -: 4];
        if (k % 2 == 0) begin
          pe[4*pc +: 4] = v;
          pc++;
        end else begin
          de[4*dc +: 4] = v;
          dc++;
        end
        feed(v);
      end
      for (int k = 0; k < int'(vt[i].nh); k++) begin
        v = vt[i].ph[31-4*k -: 4];
        pe[4*pc +: 4] = v;
        pc++;
        wait_turn();
        pulse(1);
        feed(v);
      end
      if (vt[i].st) begin
        wait_turn();
        pulse(2);
      end
      for (int k = 0; k < int'(vt[i].nd); k++) begin
        v = vt[i].dd[15-4*k -: 4];
        de[4*dc +: 4] = v;
        dc++;
        feed(v);
      end
      wait_result();
      chk($sformatf("v%0d_res", i), 64'(result), 64'(vt[i].res));
      chk($sformatf("v%0d_pc", i), 64'(player_cards), 64'(pe));
      chk($sformatf("v%0d_dc", i), 64'(dealer_cards), 64'(de));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      repeat (3) tick();
      chk($sformatf("v%0d_noreq", i), 64'(card_req), 64'd0);
      chk($sformatf("v%0d_hold", i), 64'(result_valid), 64'd1);
    end

    // Handshake stalls, illegal codes, stray valid, then hit+stand together
    pulse(0);
    wait_req();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_req", 64'(card_req), 64'd1);
    end
    card_valid = 1'b1;
    card_value = 4'd0;
    tick();
    chk("zero_req", 64'(card_req), 64'd1);
    chk("zero_pc", 64'(player_cards), 64'd0);
    card_value = 4'd14;
    tick();
    chk("c14_req", 64'(card_req), 64'd1);
    chk("c14_pc", 64'(player_cards), 64'd0);
    card_value = 4'd4;
    tick();
    chk("four_pc", 64'(player_cards), 64'h4);
    chk("four_req", 64'(card_req), 64'd0);
    card_value = 4'd9;
    tick();
    chk("stray_dc", 64'(dealer_cards), 64'd0);
    card_valid = 1'b0;
    card_value = 4'd0;
    feed(4'd10);
    feed(4'd5);
    feed(4'd10);
    wait_turn();
    hit = 1'b1;
    stand = 1'b1;
    tick();
    hit = 1'b0;
    stand = 1'b0;
    wait_result();
    chk("hs_res", 64'(result), 64'h2);
    chk("hs_pc", 64'(player_cards), 64'h54);

    // Asynchronous reset while the dealer waits for a card
    pulse(0);
    feed(4'd10);
    feed(4'd2);
    feed(4'd8);
    feed(4'd3);
    wait_turn();
    pulse(2);
    wait_req();
    #3 rst = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_req", 64'(card_req), 64'd0);
    chk("mid_pc", 64'(player_cards), 64'd0);
    chk("mid_dc", 64'(dealer_cards), 64'd0);
    chk("mid_res", 64'({result, result_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mid_idle", 64'(busy), 64'd0);

    // Idle player turn: P17 vs D19 until a 2 makes it a push
    pulse(0);
    feed(4'd10);
    feed(4'd10);
    feed(4'd7);
    feed(4'd9);
    wait_turn();
`ifdef BLACKJACK_TURN_TIMEOUT_EN
    repeat (TMO - 2) tick();
    chk("tmo_pre_hit", 64'(player_turn), 64'd1);
    pulse(1);
    feed(4'd2);
    wait_turn();
    repeat (TMO - 1) tick();
    chk("tmo_hold", 64'(player_turn), 64'd1);
    tick();
    chk("tmo_fire", 64'(player_turn), 64'd0);
    chk("tmo_busy", 64'(busy), 64'd1);
`else
    repeat (40) tick();
    chk("no_tmo", 64'(player_turn), 64'd1);
    pulse(1);
    feed(4'd2);
    wait_turn();
    pulse(2);
`endif
    wait_result();
    chk("tmo_res", 64'(result), 64'h3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/blackjack_turn_ctrl.md
Name: blackjack_turn_ctrl

Overview:
- Game-flow sequencer for one blackjack round.
- Requests cards from the deck source over a req/valid handshake and writes them into player and dealer hand-slot registers.
- Those slot registers feed two card-value calculator instances (player, dealer). The calculators return registered totals.
- Sequences the initial deal, the player hit/stand turn and the dealer draw-to-threshold turn, then publishes the round outcome.

Parameters:
- MAX_CARDS, 9, hand slots per side; the calculator sums exactly 9 slots.
- DEALER_STAND, 17, dealer stops drawing at a total of this value or more.
- SETTLE_CYCLES, 2, wait after each slot write before a total is sampled; covers the calculator's registered output. Legal range 2..15.
- TIMEOUT_CYCLES, 1000, idle player-turn limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (low = reset)
- start  in  1  one-cycle pulse; begins a round
- hit  in  1  one-cycle pulse; player requests a card
- stand  in  1  one-cycle pulse; player ends turn
- card_req  out  1  card request to deck source
- card_valid  in  1  deck source presents card_value
- card_value  in  4  card code 1..13 (1 = ace, 11..13 = face cards)
- player_cards  out  36  slot i at bits [4i+3:4i]; 0 = empty
- dealer_cards  out  36  same layout as player_cards
- player_total  in  6  registered total from the player calculator
- dealer_total  in  6  registered total from the dealer calculator
- player_turn  out  1  high in P_WAIT
- busy  out  1  high in every state except IDLE and RESULT
- result  out  2  00 none, 01 win, 10 lose, 11 push
- result_valid  out  1  high in RESULT

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All slots = 0, card_req = 0, result = 00, result_valid = 0.
  - Card counters = 0, settle counter = 0.
  - Applies at any point mid-round; no partial state survives.
- Card handshake:
  - card_req rises the cycle after a state needs a card and stays high until accepted.
  - A card is accepted on a clk edge where card_req & card_valid & card_value in 1..13.
  - A card_value of 0 or 14..15 is discarded; card_req stays high.
  - card_req is low the cycle after acceptance.
  - card_valid while card_req = 0 is ignored.
- Slot write:
  - The accepted card goes to slot [count] of the target side; count then increments.
  - A write into a full side (count = MAX_CARDS) never occurs.
- States:
  - IDLE: start -> DEAL.
  - DEAL: draws 4 cards in order P, D, P, D, then SETTLE_CYCLES wait, then -> P_WAIT.
  - P_WAIT:
    - stand -> D_CHECK.
    - hit -> P_DRAW.
    - hit and stand in the same cycle: stand wins.
    - Entered with player_total > 21 -> RESULT (lose).
    - Entered with player count = MAX_CARDS -> D_CHECK (forced stand).
  - P_DRAW: one card to the player, then P_SETTLE.
  - P_SETTLE: wait SETTLE_CYCLES, then -> P_WAIT. hit/stand are ignored in P_DRAW and P_SETTLE.
  - D_CHECK:
    - dealer_total >= DEALER_STAND or dealer count = MAX_CARDS -> RESULT.
    - Otherwise -> D_DRAW.
  - D_DRAW: one card to the dealer, then D_SETTLE (SETTLE_CYCLES), then -> D_CHECK.
  - RESULT: holds outputs. start clears all slots and counters the same cycle and -> DEAL.
- start outside IDLE/RESULT is ignored.
- Result, evaluated with 6-bit unsigned totals, first matching rule wins:
  - player > 21 -> 10 (lose).
  - dealer > 21 -> 01 (win).
  - player > dealer -> 01 (win).
  - player < dealer -> 10 (lose).
  - equal -> 11 (push).
- result and result_valid are registered and are asserted the cycle RESULT is entered.

Optional Feature:
- Macro: BLACKJACK_TURN_TIMEOUT_EN.
- Defined:
  - A counter runs while in P_WAIT and clears on leaving P_WAIT or on any hit/stand.
  - Reaching TIMEOUT_CYCLES consecutive idle cycles acts as stand.
- Undefined: no counter; P_WAIT waits indefinitely.

Test Plan:
- Deal order:
  - Stimulus: reset, start, deck supplies 10, 7, 9, 5.
  - Response: player_cards = {..,9,10}, dealer_cards = {..,5,7}; P_WAIT with totals 19/12.
- Player stand, dealer draws:
  - Stimulus: player stands on 19; dealer 12 receives 6.
  - Response: dealer 18, no further card_req; result = 01, result_valid = 1.
- Player bust:
  - Stimulus: player 10+6, hit, deck supplies 13.
  - Response: total 26; RESULT with 10; dealer receives no cards.
- Handshake corner cases:
  - Stimulus: card_valid held low 5 cycles, then value 0, then 4.
  - Response: card_req stays high throughout; only 4 is written.
  - Stimulus: hit and stand asserted in the same cycle.
  - Response: treated as stand.
- Push and restart:
  - Stimulus: player 10+8, dealer 10+8; stand -> result 11; then start.
  - Response: all slots clear and a new deal begins.
  - Stimulus: rst low mid-D_DRAW.
  - Response: IDLE and all outputs zero immediately.
- Timeout (macro defined, TIMEOUT_CYCLES = 20):
  - Stimulus: no input for 20 cycles in P_WAIT.
  - Response: D_CHECK entered.
  - Stimulus: hit at cycle 19.
  - Response: counter restarts.
